// File: rtl/ds1302_ctrl.sv
// ---------------------------------------------------------------------------
// ds1302_ctrl
//
// Three-wire serial master for the DS1302 real-time clock. After reset it
// clears write-protect and loads a start time. It then polls the seconds,
// minutes and hours registers and publishes the time as packed BCD and as an
// 8-nibble display word. Single-shot time-set requests are queued behind the
// current read burst, or serviced at once while the poll timer is running.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   set_req     one-cycle time-set request
//   set_time    {hh,mm,ss} BCD, captured together with set_req
//   ds_ce       DS1302 CE/RST pin
//   ds_sclk     DS1302 serial clock
//   ds_io       DS1302 bidirectional data, driven only while writing
//   time_bcd    last time read back, {hh,mm,ss}
//   seg_number  display word: H1 H0 SEP M1 M0 SEP S1 S0
//   time_valid  one-cycle pulse when time_bcd / seg_number update
//   set_ack     one-cycle pulse when a set sequence has been written
//   busy        high while a transaction (CE setup to gap) is in progress
// ---------------------------------------------------------------------------
module ds1302_ctrl #(
    parameter int          SCLK_HALF   = 50,
    parameter int          POLL_CYCLES = 5_000_000,
    parameter logic [23:0] INIT_TIME   = 24'h235950,
    parameter logic [3:0]  SEP_CODE    = 4'hA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set_req,
    input  logic [23:0] set_time,
    output logic        ds_ce,
    output logic        ds_sclk,
    inout  wire         ds_io,
    output logic [23:0] time_bcd,
    output logic [31:0] seg_number,
    output logic        time_valid,
    output logic        set_ack,
    output logic        busy
);

    typedef enum logic [2:0] {
        E_IDLE,
        E_CE_SETUP,
        E_BIT_LO,
        E_BIT_HI,
        E_CE_HOLD,
        E_GAP
    } eng_t;

    typedef enum logic [1:0] {
        SQ_INIT,
        SQ_SET,
        SQ_READ,
        SQ_WAIT
    } seq_t;

    localparam logic [15:0] HALF_LAST = 16'(SCLK_HALF - 1);
    localparam logic [15:0] GAP_LAST  = 16'(2 * SCLK_HALF - 1);
    localparam logic [31:0] POLL_LAST = 32'(POLL_CYCLES - 1);

    eng_t        eng;
    seq_t        seq;
    logic [1:0]  idx;
    logic [15:0] cnt;
    logic [3:0]  slot;
    logic [15:0] shreg;
    logic [7:0]  rx;
    logic        is_read;
    logic        io_oe;
    logic        io_out;
    logic        pending;
    logic [23:0] set_latch;
    logic [23:0] set_active;
    logic [7:0]  rd_sec;
    logic [7:0]  rd_min;
    logic [31:0] wait_cnt;

    seq_t        nxt_seq;
    logic [1:0]  nxt_idx;
    logic        launch;
    logic        take_set;
    logic        finish_read;
    logic        finish_set;
    logic        gap_done;
    logic        f_read;
    logic [7:0]  f_cmd;
    logic [7:0]  f_data;
    logic [23:0] src_time;

    logic [7:0]  hr_m;
    logic [7:0]  min_m;
    logic [7:0]  sec_m;

    assign ds_io    = io_oe ? io_out : 1'bz;
    assign busy     = (eng != E_IDLE);
    assign gap_done = (eng == E_GAP) && (cnt == GAP_LAST);

    // The hours byte is still in the receive shifter when the burst ends.
    assign hr_m  = rx & 8'h3F;
    assign min_m = rd_min & 8'h7F;
    assign sec_m = rd_sec & 8'h7F;

    // Sequencer: decides which frame goes next. A new frame is launched
    // straight out of the final gap cycle so back-to-back transactions
    // have no idle cycle between them.
    always_comb begin
        nxt_seq     = seq;
        nxt_idx     = idx;
        launch      = 1'b0;
        take_set    = 1'b0;
        finish_read = 1'b0;
        finish_set  = 1'b0;
        if (eng == E_IDLE) begin
            if (seq != SQ_WAIT) begin
                launch = 1'b1;
            end else if (pending) begin
                nxt_seq  = SQ_SET;
                nxt_idx  = 2'd0;
                launch   = 1'b1;
                take_set = 1'b1;
            end else if (wait_cnt == POLL_LAST) begin
                nxt_seq = SQ_READ;
                nxt_idx = 2'd0;
                launch  = 1'b1;
            end
        end else if (gap_done) begin
            case (seq)
                SQ_INIT, SQ_SET: begin
                    if (idx != 2'd3) begin
                        nxt_idx = idx + 2'd1;
                        launch  = 1'b1;
                    end else if (seq == SQ_INIT && pending) begin
                        nxt_seq  = SQ_SET;
                        nxt_idx  = 2'd0;
                        launch   = 1'b1;
                        take_set = 1'b1;
                    end else begin
                        nxt_seq    = SQ_READ;
                        nxt_idx    = 2'd0;
                        launch     = 1'b1;
                        finish_set = (seq == SQ_SET);
                    end
                end
                SQ_READ: begin
                    if (idx != 2'd2) begin
                        nxt_idx = idx + 2'd1;
                        launch  = 1'b1;
                    end else begin
                        finish_read = 1'b1;
                        nxt_idx     = 2'd0;
                        if (pending) begin
                            nxt_seq  = SQ_SET;
                            launch   = 1'b1;
                            take_set = 1'b1;
                        end else begin
                            nxt_seq = SQ_WAIT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Frame contents for the transaction about to be launched. A set that is
    // just being taken uses the latch directly, since set_active only picks it
    // up on the same edge.
    always_comb begin
        f_read   = 1'b0;
        f_cmd    = 8'h00;
        f_data   = 8'h00;
        src_time = INIT_TIME;
        if (nxt_seq == SQ_SET) begin
            src_time = take_set ? set_latch : set_active;
        end
        if (nxt_seq == SQ_READ) begin
            f_read = 1'b1;
            f_cmd  = 8'h81 + {5'd0, nxt_idx, 1'b0};
        end else begin
            case (nxt_idx)
                2'd0: begin
                    f_cmd  = 8'h8E;
                    f_data = 8'h00;
                end
                2'd1: begin
                    f_cmd  = 8'h80;
                    f_data = src_time[7:0] & 8'h7F;
                end
                2'd2: begin
                    f_cmd  = 8'h82;
                    f_data = src_time[15:8] & 8'h7F;
                end
                default: begin
                    f_cmd  = 8'h84;
                    f_data = src_time[23:16] & 8'h3F;
                end
            endcase
        end
    end

    // Transaction engine plus all registered outputs. shreg holds the
    // remaining frame bits with the current bit at position 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng        <= E_IDLE;
            seq        <= SQ_INIT;
            idx        <= 2'd0;
            cnt        <= 16'd0;
            slot       <= 4'd0;
            shreg      <= 16'd0;
            rx         <= 8'd0;
            is_read    <= 1'b0;
            io_oe      <= 1'b0;
            io_out     <= 1'b0;
            pending    <= 1'b0;
            set_latch  <= 24'd0;
            set_active <= 24'd0;
            rd_sec     <= 8'd0;
            rd_min     <= 8'd0;
            wait_cnt   <= 32'd0;
            ds_ce      <= 1'b0;
            ds_sclk    <= 1'b0;
            time_bcd   <= 24'd0;
            seg_number <= {8'h00, SEP_CODE, 8'h00, SEP_CODE, 8'h00};
            time_valid <= 1'b0;
            set_ack    <= 1'b0;
        end else begin
            seq        <= nxt_seq;
            idx        <= nxt_idx;
            time_valid <= finish_read;
            set_ack    <= finish_set;
            wait_cnt   <= (eng == E_IDLE && seq == SQ_WAIT && !launch) ?
                          wait_cnt + 32'd1 : 32'd0;

            // A request on the same edge as a take wins and stays pending.
            if (take_set) begin
                set_active <= set_latch;
                pending    <= 1'b0;
            end
            if (set_req) begin
                pending   <= 1'b1;
                set_latch <= set_time;
            end

            if (gap_done && seq == SQ_READ) begin
                if (idx == 2'd0) begin
                    rd_sec <= rx;
                end else if (idx == 2'd1) begin
                    rd_min <= rx;
                end
            end

            if (finish_read) begin
                time_bcd   <= {hr_m, min_m, sec_m};
                seg_number <= {hr_m, SEP_CODE, min_m, SEP_CODE, sec_m};
            end

            if (launch) begin
                eng     <= E_CE_SETUP;
                cnt     <= 16'd0;
                slot    <= 4'd0;
                shreg   <= {f_data, f_cmd};
                is_read <= f_read;
                io_oe   <= 1'b1;
                io_out  <= f_cmd[0];
                ds_ce   <= 1'b1;
                ds_sclk <= 1'b0;
            end else begin
                cnt <= cnt + 16'd1;
                case (eng)
                    E_IDLE: begin
                        cnt <= 16'd0;
                    end
                    E_CE_SETUP: begin
                        if (cnt == HALF_LAST) begin
                            eng <= E_BIT_LO;
                            cnt <= 16'd0;
                        end
                    end
                    E_BIT_LO: begin
                        if (cnt == HALF_LAST) begin
                            eng     <= E_BIT_HI;
                            cnt     <= 16'd0;
                            ds_sclk <= 1'b1;
                            if (is_read && slot[3]) begin
                                rx <= {ds_io, rx[7:1]};
                            end
                        end
                    end
                    E_BIT_HI: begin
                        if (cnt == HALF_LAST) begin
                            cnt     <= 16'd0;
                            ds_sclk <= 1'b0;
                            if (slot == 4'd15) begin
                                eng   <= E_CE_HOLD;
                                io_oe <= 1'b0;
                            end else begin
                                eng    <= E_BIT_LO;
                                slot   <= slot + 4'd1;
                                shreg  <= shreg >> 1;
                                io_out <= shreg[1];
                                // Hand the bus to the DS1302 for the data byte.
                                if (is_read && slot == 4'd7) begin
                                    io_oe <= 1'b0;
                                end
                            end
                        end
                    end
                    E_CE_HOLD: begin
                        if (cnt == HALF_LAST) begin
                            eng   <= E_GAP;
                            cnt   <= 16'd0;
                            ds_ce <= 1'b0;
                        end
                    end
                    E_GAP: begin
                        if (cnt == GAP_LAST) begin
                            eng <= E_IDLE;
                            cnt <= 16'd0;
                        end
                    end
                    default: begin
                        eng <= E_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ds1302_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ds1302_ctrl
//
// Bench for ds1302_ctrl with SCLK_HALF=4 and POLL_CYCLES=200. A behavioural
// DS1302 model decodes every frame on the three-wire bus, keeps a small
// register file updated by writes and answers reads. Expected frames and
// expected time reports are queued as stimulus is applied and checked as the
// DUT produces them.
// ---------------------------------------------------------------------------
module tb_ds1302_ctrl;

    localparam int SH   = 4;
    localparam int POLL = 200;
    localparam int TXN  = 36 * SH;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        int         gap;
    } txn_t;

    typedef struct {
        logic [23:0] t;
        int          gap;
    } tv_t;

    typedef struct {
        logic [7:0]  sec;
        logic [7:0]  min;
        logic [7:0]  hr;
        logic [23:0] expect_time;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        set_req;
    logic [23:0] set_time;
    logic        ds_ce;
    logic        ds_sclk;
    wire         ds_io;
    logic [23:0] time_bcd;
    logic [31:0] seg_number;
    logic        time_valid;
    logic        set_ack;
    logic        busy;

    logic        model_oe;
    logic        model_bit;
    logic [7:0]  regs [8];

    int          n_vec;
    int          n_err;
    int unsigned cyc;
    int unsigned last_rise;
    int unsigned cur_period;
    int unsigned last_valid;
    int          valid_cnt;
    int          ack_cnt;
    logic [4:0]  rise_cnt;
    logic [15:0] bits;
    logic        prev_ce;
    logic        prev_sclk;
    logic        prev_valid;
    logic        prev_ack;

    txn_t        exp_txn [$];
    tv_t         exp_tv  [$];
    vec_t        vecs    [6];

    assign ds_io = model_oe ? model_bit : 1'bz;

    ds1302_ctrl #(
        .SCLK_HALF  (SH),
        .POLL_CYCLES(POLL),
        .INIT_TIME  (24'h235950),
        .SEP_CODE   (4'hA)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_req   (set_req),
        .set_time  (set_time),
        .ds_ce     (ds_ce),
        .ds_sclk   (ds_sclk),
        .ds_io     (ds_io),
        .time_bcd  (time_bcd),
        .seg_number(seg_number),
        .time_valid(time_valid),
        .set_ack   (set_ack),
        .busy      (busy)
    );

    // 100 MHz-style bench clock; absolute frequency is irrelevant here.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running cycle counter used for all timing measurements.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case the sequencer wedges somewhere no bounded wait covers.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    function automatic logic [31:0] seg_of(input logic [23:0] t);
        return {t[23:16], 4'hA, t[15:8], 4'hA, t[7:0]};
    endfunction

    task automatic push_txn(input logic [7:0] cmd, input logic [7:0] data,
                            input int gap);
        txn_t e;
        e.cmd  = cmd;
        e.data = data;
        e.gap  = gap;
        exp_txn.push_back(e);
    endtask

    task automatic push_tv(input logic [23:0] t, input int gap);
        tv_t e;
        e.t   = t;
        e.gap = gap;
        exp_tv.push_back(e);
    endtask

    task automatic push_reads(input int first_gap);
        push_txn(8'h81, 8'h00, first_gap);
        push_txn(8'h83, 8'h00, TXN);
        push_txn(8'h85, 8'h00, TXN);
    endtask

    // Expected write frames for one set sequence, data already masked.
    task automatic push_writes(input int first_gap, input logic [7:0] s,
                               input logic [7:0] m, input logic [7:0] h);
        push_txn(8'h8E, 8'h00, first_gap);
        push_txn(8'h80, s, TXN);
        push_txn(8'h82, m, TXN);
        push_txn(8'h84, h, TXN);
    endtask

    task automatic applyStimulus(input vec_t v);
        regs[0] = v.sec;
        regs[1] = v.min;
        regs[2] = v.hr;
        push_reads(POLL + TXN);
        push_tv(v.expect_time, POLL + 3 * TXN);
    endtask

    task automatic pulse_set(input logic [23:0] t);
        @(negedge clk);
        set_req  = 1'b1;
        set_time = t;
        @(negedge clk);
        set_req  = 1'b0;
        set_time = 24'h000000;
    endtask

    task automatic wait_valid(input string name);
        int start;
        start = valid_cnt;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (valid_cnt != start) return;
        end
        checkOutput({name, "_timeout"}, 32'(valid_cnt - start), 32'd1);
    endtask

    task automatic wait_ce_rise(input string name);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (ds_ce) return;
        end
        checkOutput({name, "_ce_timeout"}, 32'(ds_ce), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_ce"}, 32'(ds_ce), 32'd0);
        checkOutput({tag, "_sclk"}, 32'(ds_sclk), 32'd0);
        checkOutput({tag, "_time_bcd"}, 32'(time_bcd), 32'd0);
        checkOutput({tag, "_seg"}, seg_number, 32'h00A00A00);
        checkOutput({tag, "_valid"}, 32'(time_valid), 32'd0);
        checkOutput({tag, "_ack"}, 32'(set_ack), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // DS1302 model and scoreboard. Runs on the falling clk edge so every DUT
    // output has settled. Write bits are taken on SCLK rise; read data bits are
    // presented on SCLK fall once the command byte has been shifted in.
    always @(negedge clk) begin
        if (prev_ack) checkOutput("ack_width", 32'(set_ack), 32'd0);
        if (set_ack) begin
            ack_cnt++;
            checkOutput("ack_timing", cyc - last_rise, 32'(TXN));
        end

        if (prev_valid) checkOutput("valid_width", 32'(time_valid), 32'd0);
        if (time_valid) begin
            if (exp_tv.size() == 0) begin
                checkOutput("unexpected_valid", 32'(time_bcd), 32'hFFFFFFFF);
            end else begin
                tv_t e;
                e = exp_tv.pop_front();
                checkOutput("time_bcd", 32'(time_bcd), 32'(e.t));
                checkOutput("seg_number", seg_number, seg_of(e.t));
                if (e.gap != 0) checkOutput("poll_spacing", cyc - last_valid, 32'(e.gap));
            end
            last_valid = cyc;
            valid_cnt++;
        end

        if (ds_ce && !prev_ce) begin
            rise_cnt   = 5'd0;
            bits       = 16'd0;
            cur_period = cyc - last_rise;
            last_rise  = cyc;
        end
        if (ds_ce && ds_sclk && !prev_sclk) begin
            if (rise_cnt < 5'd16) bits[rise_cnt[3:0]] = ds_io;
            rise_cnt = rise_cnt + 5'd1;
        end
        if (ds_ce && !ds_sclk && prev_sclk) begin
            if (bits[0] && rise_cnt >= 5'd8 && rise_cnt < 5'd16) begin
                model_oe  = 1'b1;
                model_bit = regs[bits[3:1]][rise_cnt[2:0]];
            end else begin
                model_oe = 1'b0;
            end
        end
        if (!ds_ce && prev_ce) begin
            model_oe = 1'b0;
            // Frames cut short by reset are dropped without comment.
            if (rise_cnt == 5'd16) begin
                checkOutput("ce_high", cyc - last_rise, 32'(34 * SH));
                if (exp_txn.size() == 0) begin
                    checkOutput("unexpected_txn", 32'(bits), 32'hFFFFFFFF);
                end else begin
                    txn_t e;
                    e = exp_txn.pop_front();
                    checkOutput("cmd", 32'(bits[7:0]), 32'(e.cmd));
                    if (bits[0]) checkOutput("rdata_bus", 32'(bits[15:8]), 32'(regs[bits[3:1]]));
                    else         checkOutput("wdata", 32'(bits[15:8]), 32'(e.data));
                    if (e.gap != 0) checkOutput("txn_period", cur_period, 32'(e.gap));
                end
                if (!bits[0] && bits[7]) regs[bits[3:1]] = bits[15:8];
            end
        end

        prev_ce    = ds_ce;
        prev_sclk  = ds_sclk;
        prev_valid = time_valid;
        prev_ack   = set_ack;
    end

    // Main sequence: reset/INIT, table of read vectors, set requests in READ,
    // WAIT and SET, then a reset in the middle of a frame.
    initial begin
        int ack_before;
        n_vec      = 0;
        n_err      = 0;
        valid_cnt  = 0;
        ack_cnt    = 0;
        last_rise  = 0;
        last_valid = 0;
        cur_period = 0;
        rise_cnt   = 5'd0;
        bits       = 16'd0;
        prev_ce    = 1'b0;
        prev_sclk  = 1'b0;
        prev_valid = 1'b0;
        prev_ack   = 1'b0;
        model_oe   = 1'b0;
        model_bit  = 1'b0;
        set_req    = 1'b0;
        set_time   = 24'h000000;
        for (int i = 0; i < 8; i++) regs[i] = 8'h00;

        vecs[0] = '{8'h85, 8'h07, 8'h92, 24'h120705};
        vecs[1] = '{8'hA5, 8'hA5, 8'hA5, 24'h252525};
        vecs[2] = '{8'h5A, 8'h5A, 8'h5A, 24'h1A5A5A};
        vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 24'h3F7F7F};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 24'h000000};
        vecs[5] = '{8'h59, 8'h59, 8'h23, 24'h235959};

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        $display("[TB] reset release, INIT then first read burst");
        push_writes(0, 8'h50, 8'h59, 8'h23);
        push_reads(TXN);
        push_tv(24'h235950, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 checkOutput("ce_first_edge", 32'(ds_ce), 32'd1);
        wait_valid("init");

        $display("[TB] table of read vectors");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            wait_valid("vector");
        end

        $display("[TB] two set requests during READ, last one wins");
        ack_before = ack_cnt;
        push_reads(POLL + TXN);
        push_tv(24'h235959, POLL + 3 * TXN);
        wait_ce_rise("set_in_read");
        repeat (30) @(negedge clk);
        pulse_set(24'h111111);
        repeat (30) @(negedge clk);
        pulse_set(24'h081530);
        push_writes(TXN, 8'h30, 8'h15, 8'h08);
        push_reads(TXN);
        push_tv(24'h081530, 0);
        wait_valid("set_read_burst");
        wait_valid("set_read_result");
        checkOutput("ack_count_read", 32'(ack_cnt - ack_before), 32'd1);

        $display("[TB] set during WAIT, then another set during SET");
        ack_before = ack_cnt;
        push_writes(0, 8'h00, 8'h45, 8'h12);
        push_reads(TXN);
        push_tv(24'h124500, 0);
        pulse_set(24'h124500);
        wait_ce_rise("set_in_wait");
        repeat (20) @(negedge clk);
        pulse_set(24'h235800);
        push_writes(TXN, 8'h00, 8'h58, 8'h23);
        push_reads(TXN);
        push_tv(24'h235800, 0);
        wait_valid("set_wait_result");
        wait_valid("set_in_set_result");
        checkOutput("ack_count_wait", 32'(ack_cnt - ack_before), 32'd2);

        $display("[TB] reset in slot 5 of a read frame");
        wait_ce_rise("mid_reset");
        repeat (45) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        repeat (5) @(negedge clk);
        check_reset_outputs("held_reset");
        push_writes(0, 8'h50, 8'h59, 8'h23);
        push_reads(TXN);
        push_tv(24'h235950, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 checkOutput("ce_restart_edge", 32'(ds_ce), 32'd1);
        wait_valid("restart");

        checkOutput("txn_queue_empty", 32'(exp_txn.size()), 32'd0);
        checkOutput("tv_queue_empty", 32'(exp_tv.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ds1302_ctrl.md
# ds1302_ctrl

Three-wire serial master for the DS1302 real-time clock that sits directly upstream of the 8-digit display scan stage. On reset it disables write-protect and loads a start time. It then polls the seconds, minutes and hours registers at a fixed rate and presents the time both as packed BCD and as a 32-bit, 8-nibble word for the display's `seg_number_in` input. It also accepts single-shot time-set requests from the key/menu logic.

## Interface
- `SCLK_HALF`, default 50: clk cycles per SCLK half-period; must be ≥2. At 50 MHz this gives 500 kHz SCLK.
- `POLL_CYCLES`, default 5_000_000: wait between read bursts (100 ms).
- `INIT_TIME`, default 24'h235950: start time written after reset, `{hh,mm,ss}` BCD, 24 h.
- `SEP_CODE`, default 4'hA: nibble placed in separator digits 5 and 2.
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `set_req` in 1: one-cycle pulse requesting a time write.
- `set_time` in 24: `{hh,mm,ss}` BCD, sampled on the `set_req` cycle.
- `ds_ce` out 1: DS1302 CE/RST pin.
- `ds_sclk` out 1: DS1302 SCLK.
- `ds_io` inout 1: DS1302 I/O. Driven only while this block is writing; Z otherwise.
- `time_bcd` out 24: last read time, `{hh,mm,ss}`.
- `seg_number` out 32: display word. Nibbles 7..0 = `H1 H0 SEP M1 M0 SEP S1 S0`.
- `time_valid` out 1: one-cycle pulse when `time_bcd`/`seg_number` update.
- `set_ack` out 1: one-cycle pulse when a set sequence finishes.
- `busy` out 1: high from CE-setup through gap of any transaction.

## Operation
- **Transaction engine** states: IDLE → CE_SETUP → BIT_LO → BIT_HI (×16 slots) → CE_HOLD → GAP → IDLE.
- **Frame:** 16 bit-slots, LSB first.
  - Slots 0-7: command byte.
  - Slots 8-15: data byte.
  - Write command = register address (even, e.g. 0x80). Read command = address | 1.
- **Write transfers:** `ds_io` is driven in all 16 slots.
- **Read transfers:** `ds_io` is driven in slots 0-7 and released (Z) from the first cycle of slot 8 until the end of the transaction. Bit `k-8` is sampled on the last cycle of slot k's low phase.
- **Sequencer** states: INIT → (SET) → READ → WAIT → READ …
  - **INIT:** write 0x8E←0x00, 0x80←`INIT_TIME[7:0]`&0x7F, 0x82←`INIT_TIME[15:8]`&0x7F, 0x84←`INIT_TIME[23:16]`&0x3F.
  - **READ:** read 0x81, 0x83, 0x85 in that order. After the third transaction, `time_bcd` ← `{hr&0x3F, min&0x7F, sec&0x7F}` and `seg_number` is updated in the same cycle, with `time_valid` = 1 for that cycle.
  - **WAIT:** POLL_CYCLES cycles, then READ.
  - **SET:** same four writes as INIT using the latched `set_time` with the same masks (CH=0, 24 h). Then `set_ack` pulses, then an immediate READ.
- **Set-request latching:**
  - `set_req` sets a single pending flag and latches `set_time`; a later request overwrites the latched value.
  - The pending flag is serviced after INIT completes, after any READ completes, or at once if the sequencer is in WAIT (WAIT is aborted).
  - A `set_req` arriving during SET stays pending and triggers another SET after the following READ.

## Timing
- **Transaction timing** (t0 = the cycle `ds_ce` goes 1):
  - CE_SETUP: SH cycles, SCLK=0, where SH = `SCLK_HALF`.
  - Each slot: SH cycles SCLK=0 with the bit valid from the first cycle, then SH cycles SCLK=1.
  - CE_HOLD: SH cycles, SCLK=0, CE=1.
  - GAP: 2·SH cycles with CE=0.
  - Total per transaction: 36·SH cycles.
- **Back-to-back:** consecutive transactions start on the cycle after the previous GAP ends.
- **Poll period:** `time_valid` at cycle T means the next CE rise is at T+`POLL_CYCLES` and the next `time_valid` is at T+`POLL_CYCLES`+108·SH.
- **Reset values:**
  - `ds_ce`=0, `ds_sclk`=0, `ds_io`=Z.
  - `time_bcd`=0, `seg_number`=32'h00A00A00 (with the default SEP_CODE).
  - `time_valid`=0, `set_ack`=0, `busy`=0, pending flag cleared.
- **After reset release:** INIT's first CE rise occurs on the first clk edge after `rst_n` goes high.
- **Reset mid-transaction:** all outputs return to reset values asynchronously; CE drops immediately, which aborts the DS1302 transfer. The sequence restarts at INIT.

## Test plan
- **Reset-release INIT:** SH=4. Decode the first 4 transactions → 0x8E/0x00, 0x80/0x50, 0x82/0x59, 0x84/0x23, LSB first, each 144 cycles long, CE high for 136 cycles.
- **Read masking:** DS1302 model returns sec=0x85, min=0x07, hr=0x92 → `time_bcd`=24'h120705, `seg_number`=32'h12A07A05, `time_valid` is a single-cycle pulse.
- **Bus release:** during read slots 8-15 the DUT never drives `ds_io`. A model-driven bit pattern 0xA5 is captured exactly.
- **Set during READ:** `set_req` with 24'h081530 during READ → burst completes, then writes 0x8E/00, 0x80/30, 0x82/15, 0x84/08, then `set_ack`, then READ reports 24'h081530.
- **Poll spacing:** POLL_CYCLES=200, SH=4 → `time_valid` pulses exactly 632 cycles apart.
- **Mid-transaction reset:** `rst_n` low in slot 5 → `ds_ce`/`ds_sclk` go 0 and `ds_io` goes Z before the next clk edge, outputs hold reset values, and after release INIT repeats from 0x8E.
